// File: rtl/mem_stage_pipe.sv
// Registered MEM stage: branch resolve, sub-word load/store with LATENCY wait states, SLT/ALU select.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage_pipe #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_Address,
  input  logic [WIDTH-1:0] i_WriteData,
  input  logic [2:0]       i_Funct3,
  input  logic [1:0]       i_BranchOp,
  input  logic             i_negative,
  input  logic             i_zero,
  input  logic             i_branch,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic             i_SLTc,
  output logic             o_PCSrc,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_ReadData,
  output logic [WIDTH-1:0] o_Mux,
  output logic             o_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic             accept_s, mem_op_s, done_s, capture_s, taken_s;

  logic [AW+1:0]    req_addr_r;
  logic [WIDTH-1:0] req_wdata_r, req_mux_r;
  logic [2:0]       req_f3_r;
  logic             req_rd_r, req_wr_r;

  logic [AW+1:0]    a_addr_s;
  logic [AW-1:0]    a_idx_s;
  logic [WIDTH-1:0] a_wdata_s, a_mux_s, mux_sel_s;
  logic [2:0]       a_f3_s;
  logic             a_rd_s, a_wr_s, mis_en_s;
  logic [3:0]       be_s, store_be_s;
  logic [WIDTH-1:0] wrep_s, word_s, load_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic             unused_addr_s;

  logic [WIDTH-1:0] mem_r [DEPTH];

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction
`endif

  assign o_ready       = (state_r == ST_IDLE);
  assign accept_s      = i_valid & o_ready;
  assign mem_op_s      = i_MemRead | i_MemWrite;
  assign o_PCSrc       = accept_s & i_branch & taken_s;
  assign mux_sel_s     = i_SLTc ? {{(WIDTH-1){1'b0}}, i_negative} : i_Address;
  assign unused_addr_s = ^i_Address[WIDTH-1:AW+2];

  // Branch condition from ALU flags
  always_comb begin
    taken_s = 1'b0;
    case (i_BranchOp)
      2'b00:   taken_s = i_zero;
      2'b01:   taken_s = ~i_zero;
      2'b10:   taken_s = i_negative;
      2'b11:   taken_s = ~i_negative;
      default: taken_s = 1'b0;
    endcase
  end

  // Next state, wait counter and access-complete strobe
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    done_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (mem_op_s && (LATENCY > 0)) begin
            capture_s = 1'b1;
            cnt_s     = CNT_INIT;
            state_s   = ST_WAIT;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Access operands come from the held request while waiting, else straight from EX
  always_comb begin
    if (state_r == ST_WAIT) begin
      a_addr_s  = req_addr_r;
      a_wdata_s = req_wdata_r;
      a_f3_s    = req_f3_r;
      a_rd_s    = req_rd_r;
      a_wr_s    = req_wr_r;
      a_mux_s   = req_mux_r;
    end else begin
      a_addr_s  = i_Address[AW+1:0];
      a_wdata_s = i_WriteData;
      a_f3_s    = i_Funct3;
      a_rd_s    = i_MemRead;
      a_wr_s    = i_MemWrite;
      a_mux_s   = mux_sel_s;
    end
  end

  assign a_idx_s = a_addr_s[AW+1:2];
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_en_s = (a_rd_s | a_wr_s) & misaligned(a_f3_s, a_addr_s[1:0]);
`else
  assign mis_en_s = 1'b0;
`endif

  // Byte-lane enables and lane-replicated store data; low bits beyond the size are ignored
  always_comb begin
    be_s   = 4'b0000;
    wrep_s = {WIDTH{1'b0}};
    case (a_f3_s[1:0])
      2'b00: begin
        be_s   = 4'b0001 << a_addr_s[1:0];
        wrep_s = {4{a_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s   = a_addr_s[1] ? 4'b1100 : 4'b0011;
        wrep_s = {2{a_wdata_s[15:0]}};
      end
      2'b10: begin
        be_s   = 4'b1111;
        wrep_s = a_wdata_s;
      end
      default: be_s = 4'b0000;
    endcase
  end

  assign store_be_s = (a_wr_s && !mis_en_s) ? be_s : 4'b0000;
  assign word_s     = mem_r[a_idx_s];
  assign byte_s     = word_s[{a_addr_s[1:0], 3'b000} +: 8];
  assign half_s     = a_addr_s[1] ? word_s[31:16] : word_s[15:0];

  // Load extraction and extension; stores, misaligned and non-loads yield zero
  always_comb begin
    load_s = {WIDTH{1'b0}};
    if (a_rd_s && !a_wr_s && !mis_en_s) begin
      case (a_f3_s)
        3'b000:  load_s = {{(WIDTH-8){byte_s[7]}}, byte_s};
        3'b100:  load_s = {{(WIDTH-8){1'b0}}, byte_s};
        3'b001:  load_s = {{(WIDTH-16){half_s[15]}}, half_s};
        3'b101:  load_s = {{(WIDTH-16){1'b0}}, half_s};
        3'b010:  load_s = word_s;
        default: load_s = {WIDTH{1'b0}};
      endcase
    end else begin
      load_s = {WIDTH{1'b0}};
    end
  end

  // Data array write; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (done_s && !i_reset && store_be_s[b]) begin
        mem_r[a_idx_s][8*b +: 8] <= wrep_s[8*b +: 8];
      end
    end
  end

  // Control state, held request and registered results toward WB
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      req_addr_r  <= '0;
      req_wdata_r <= {WIDTH{1'b0}};
      req_mux_r   <= {WIDTH{1'b0}};
      req_f3_r    <= 3'b000;
      req_rd_r    <= 1'b0;
      req_wr_r    <= 1'b0;
      o_valid     <= 1'b0;
      o_ReadData  <= {WIDTH{1'b0}};
      o_Mux       <= {WIDTH{1'b0}};
      o_misalign  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      o_valid <= done_s;
      if (capture_s) begin
        req_addr_r  <= i_Address[AW+1:0];
        req_wdata_r <= i_WriteData;
        req_mux_r   <= mux_sel_s;
        req_f3_r    <= i_Funct3;
        req_rd_r    <= i_MemRead;
        req_wr_r    <= i_MemWrite;
      end
      if (done_s) begin
        o_ReadData <= load_s;
        o_Mux      <= a_mux_s;
        o_misalign <= mis_en_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a LATENCY=0 and a LATENCY=3 instance share the EX-side inputs.
// Misalignment expectations follow MEM_MISALIGN_CHECK_EN.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid3;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic [1:0]  bop;
  logic        neg, zero, br, mw, mr, sltc;

  logic        rdy0, pcs0, v0, mis0;
  logic [31:0] rd0, mux0;
  logic        rdy3, pcs3, v3, mis3;
  logic [31:0] rd3, mux3;

  int errors = 0;
  int checks = 0;
  int vcount;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  always #5 clk = ~clk;

  mem_stage_pipe #(.WIDTH(32), .DEPTH(256), .LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid0), .o_ready(rdy0),
    .i_Address(addr), .i_WriteData(wdata), .i_Funct3(f3), .i_BranchOp(bop),
    .i_negative(neg), .i_zero(zero), .i_branch(br), .i_MemWrite(mw),
    .i_MemRead(mr), .i_SLTc(sltc), .o_PCSrc(pcs0), .o_valid(v0),
    .o_ReadData(rd0), .o_Mux(mux0), .o_misalign(mis0)
  );

  mem_stage_pipe #(.WIDTH(32), .DEPTH(256), .LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid3), .o_ready(rdy3),
    .i_Address(addr), .i_WriteData(wdata), .i_Funct3(f3), .i_BranchOp(bop),
    .i_negative(neg), .i_zero(zero), .i_branch(br), .i_MemWrite(mw),
    .i_MemRead(mr), .i_SLTc(sltc), .o_PCSrc(pcs3), .o_valid(v3),
    .o_ReadData(rd3), .o_Mux(mux3), .o_misalign(mis3)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic r, input logic w);
    addr = a; wdata = d; f3 = f; mr = r; mw = w; br = 1'b0; sltc = 1'b0;
  endtask

  // One LATENCY=0 operation: present at negedge, land on the next posedge, return 1 unit later.
  task automatic step0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic r, input logic w);
    @(negedge clk);
    drive(a, d, f, r, w);
    valid0 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0;
    drive(32'h0, 32'h0, F_W, 1'b0, 1'b0);
    bop = 2'b00; neg = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rd0); end
    checks++; if (mux0 !== 32'h0) begin errors++; $display("FAIL reset_mux: got %h want 0", mux0); end
    checks++; if (mis0 !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", mis0); end
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL reset_valid3: got %b want 0", v3); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", rdy0); end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b want 1", rdy3); end
  endtask

  task automatic test_word;
    step0(32'h10, 32'hDEADBEEF, F_W, 1'b0, 1'b1);
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b want 1", v0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rd0); end
    checks++; if (mux0 !== 32'h10) begin errors++; $display("FAIL sw_mux: got %h want 10", mux0); end
    step0(32'h10, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b want 1", v0); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd0); end
    @(negedge clk);
    valid0 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", v0); end
  endtask

  task automatic test_subword;
    step0(32'h20, 32'h11223344, F_W, 1'b0, 1'b1);
    step0(32'h21, 32'h00000080, F_B, 1'b0, 1'b1);
    step0(32'h21, 32'h0, F_B, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", rd0); end
    step0(32'h21, 32'h0, F_BU, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd0); end
    step0(32'h20, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'h11228044) begin errors++; $display("FAIL sb_lanes: got %h want 11228044", rd0); end
    step0(32'h22, 32'h0000BEEF, F_H, 1'b0, 1'b1);
    step0(32'h22, 32'h0, F_H, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh: got %h want ffffbeef", rd0); end
    step0(32'h22, 32'h0, F_HU, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'h0000BEEF) begin errors++; $display("FAIL lhu: got %h want 0000beef", rd0); end
    step0(32'h20, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'hBEEF8044) begin errors++; $display("FAIL sh_lanes: got %h want beef8044", rd0); end
    step0(32'h24, 32'h00000077, F_W, 1'b1, 1'b1);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rdwr_rdata: got %h want 0", rd0); end
    step0(32'h24, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'h00000077) begin errors++; $display("FAIL rdwr_store: got %h want 00000077", rd0); end
    step0(32'h410, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL addr_wrap: got %h want deadbeef", rd0); end
    @(negedge clk);
    valid0 = 1'b0;
  endtask

  task automatic test_latency;
    @(negedge clk);
    drive(32'h30, 32'hA5A50F0F, F_W, 1'b0, 1'b1);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL lat_ready_e0: got %b want 0", rdy3); end
    @(negedge clk);
    drive(32'h30, 32'h0, F_W, 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rdy3 !== 1'b0 || v3 !== 1'b0) begin
        errors++; $display("FAIL lat_wait_e%0d: ready=%b valid=%b want 0 0", i, rdy3, v3);
      end
    end
    @(posedge clk);
    #1;
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL lat_store_valid: got %b want 1", v3); end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL lat_ready_back: got %b want 1", rdy3); end
    checks++; if (mux3 !== 32'h30) begin errors++; $display("FAIL lat_store_mux: got %h want 30", mux3); end
    @(posedge clk);
    #1;
    checks++;
    if (v3 !== 1'b0 || rdy3 !== 1'b0) begin
      errors++; $display("FAIL lat_held_accept: valid=%b ready=%b want 0 0", v3, rdy3);
    end
    @(negedge clk);
    valid3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL lat_load_valid: got %b want 1", v3); end
    checks++; if (rd3 !== 32'hA5A50F0F) begin errors++; $display("FAIL lat_load_data: got %h want a5a50f0f", rd3); end
  endtask

  task automatic test_branch;
    @(negedge clk);
    drive(32'h0, 32'h0, F_W, 1'b0, 1'b0);
    valid0 = 1'b1; br = 1'b1; bop = 2'b10; neg = 1'b1; zero = 1'b0;
    #1;
    checks++; if (pcs0 !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b want 1", pcs0); end
    @(negedge clk);
    bop = 2'b11;
    #1;
    checks++; if (pcs0 !== 1'b0) begin errors++; $display("FAIL bge_not: got %b want 0", pcs0); end
    @(negedge clk);
    bop = 2'b01; zero = 1'b1;
    #1;
    checks++; if (pcs0 !== 1'b0) begin errors++; $display("FAIL bne_not: got %b want 0", pcs0); end
    @(negedge clk);
    bop = 2'b00;
    #1;
    checks++; if (pcs0 !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", pcs0); end
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (pcs0 !== 1'b0) begin errors++; $display("FAIL nobranch: got %b want 0", pcs0); end
    @(negedge clk);
    br = 1'b1; valid0 = 1'b0;
    #1;
    checks++; if (pcs0 !== 1'b0) begin errors++; $display("FAIL novalid: got %b want 0", pcs0); end
    @(negedge clk);
    br = 1'b0; neg = 1'b0; zero = 1'b0;
  endtask

  task automatic test_slt;
    @(negedge clk);
    drive(32'h1234, 32'h0, F_W, 1'b0, 1'b0);
    sltc = 1'b1; neg = 1'b1; valid0 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mux0 !== 32'h1) begin errors++; $display("FAIL slt_sel: got %h want 1", mux0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL slt_rdata: got %h want 0", rd0); end
    @(negedge clk);
    sltc = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (mux0 !== 32'h1234) begin errors++; $display("FAIL alu_sel: got %h want 1234", mux0); end
    @(negedge clk);
    valid0 = 1'b0; neg = 1'b0;
  endtask

  task automatic test_misalign;
    logic        exp_mis;
    logic [31:0] exp_lw13, exp_w10;
`ifdef MEM_MISALIGN_CHECK_EN
    exp_mis = 1'b1; exp_lw13 = 32'h0; exp_w10 = 32'hDEADBEEF;
`else
    exp_mis = 1'b0; exp_lw13 = 32'hDEADBEEF; exp_w10 = 32'hDEAD5555;
`endif
    step0(32'h13, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (mis0 !== exp_mis) begin errors++; $display("FAIL lw_mis_flag: got %b want %b", mis0, exp_mis); end
    checks++; if (rd0 !== exp_lw13) begin errors++; $display("FAIL lw_mis_data: got %h want %h", rd0, exp_lw13); end
    step0(32'h11, 32'h00005555, F_H, 1'b0, 1'b1);
    checks++; if (mis0 !== exp_mis) begin errors++; $display("FAIL sh_mis_flag: got %b want %b", mis0, exp_mis); end
    step0(32'h10, 32'h0, F_W, 1'b1, 1'b0);
    checks++; if (mis0 !== 1'b0) begin errors++; $display("FAIL aligned_flag: got %b want 0", mis0); end
    checks++; if (rd0 !== exp_w10) begin errors++; $display("FAIL sh_mis_mem: got %h want %h", rd0, exp_w10); end
    @(negedge clk);
    valid0 = 1'b0;
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    drive(32'h40, 32'hCAFEF00D, F_W, 1'b0, 1'b1);
    valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL rw_first_store: got %b want 1", v3); end
    @(negedge clk);
    drive(32'h40, 32'h12345678, F_W, 1'b0, 1'b1);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got %b want 0", rdy3); end
    @(negedge clk);
    valid3 = 1'b0; rst = 1'b1;
    #1;
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL rw_async_idle: got %b want 1", rdy3); end
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (v3 !== 1'b0) vcount++;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL rw_no_valid: got %0d pulses want 0", vcount); end
    @(negedge clk);
    drive(32'h40, 32'h0, F_W, 1'b1, 1'b0);
    valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL rw_load_valid: got %b want 1", v3); end
    checks++; if (rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_mem_kept: got %h want cafef00d", rd3); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_latency();
    test_branch();
    test_slt();
    test_misalign();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
